alu_issue_ctrl: RTL and testbench

Issue and result-capture stage directly upstream of the 32-bit ALU. Accepts one operation at a time over a valid/ready handshake and registers the operands and opcode onto the ALU inputs. It holds those inputs stable for the opcode's pipeline latency, because the ALU's adder, multiplier and shifters are clocked but its output mux is not. It then captures the 64-bit ALU result and presents it on a valid/ready result port.

---
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue and result-capture stage in front of the 32-bit ALU: holds operands for the opcode's latency.
// Optional feature macro: ALU_ISSUE_ILLEGAL_TRAP_EN (trap opcode 4'b1111 and flag it on res_err).
module alu_issue_ctrl #(
    parameter int unsigned LAT_ADD = 2,
    parameter int unsigned LAT_MUL = 4,
    parameter int unsigned LAT_SHF = 1,
    parameter int unsigned LAT_CMB = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_r,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_r,
    output logic [3:0]  alu_opcode,
    input  logic [63:0] alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic [3:0]  res_opcode,
    output logic        res_err,
    output logic        busy
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OP_W  = 4;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept_c;
    logic             capture_c;

    // Remaining hold edges after accept, by opcode class.
    function automatic logic [CNT_W-1:0] class_lat(input logic [OP_W-1:0] op);
        logic [CNT_W-1:0] lat;
        case (op)
            4'b0000, 4'b0001:                   lat = CNT_W'(LAT_ADD);
            4'b0010:                            lat = CNT_W'(LAT_MUL);
            4'b0100, 4'b0101, 4'b0110, 4'b0111: lat = CNT_W'(LAT_SHF);
            default:                            lat = CNT_W'(LAT_CMB);
        endcase
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        if (op == OP_ILLEGAL) begin
            lat = '0;
        end
`endif
        return lat;
    endfunction

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && res_ready);
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        accept_c  = in_valid && in_ready;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_EXEC;
                    cnt_d   = class_lat(in_opcode);
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    capture_c = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // A same-edge result handshake and new accept skips IDLE.
                if (accept_c) begin
                    state_d = S_EXEC;
                    cnt_d   = class_lat(in_opcode);
                end else if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ALU operand registers persist outside EXEC; result registers persist outside capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_r      <= '0;
            alu_opcode <= '0;
            res_data   <= '0;
            res_opcode <= '0;
        end else begin
            if (accept_c) begin
                alu_a      <= in_a;
                alu_b      <= in_b;
                alu_r      <= in_r;
                alu_opcode <= in_opcode;
            end
            if (capture_c) begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                res_data <= (alu_opcode == OP_ILLEGAL) ? '0 : alu_out;
`else
                res_data <= alu_out;
`endif
                res_opcode <= alu_opcode;
            end
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err <= 1'b0;
        end else if (capture_c) begin
            res_err <= (alu_opcode == OP_ILLEGAL);
        end
    end
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: timeline model of accept/result cycles plus literal pinned expectations.
// Honours ALU_ISSUE_ILLEGAL_TRAP_EN when the design is built with it.
module tb_alu_issue_ctrl;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int L_MUL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        res_ready = 1'b1;
    logic [3:0]  in_opcode = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_r = '0;

    logic        in_ready, res_valid, res_err, busy;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_r;
    logic [3:0]  alu_opcode, res_opcode;
    logic [63:0] alu_out, res_data;

    logic        in_ready7, res_valid7, res_err7, busy7;
    logic [31:0] alu_a7, alu_b7;
    logic [4:0]  alu_r7;
    logic [3:0]  alu_opcode7, res_opcode7;
    logic [63:0] alu_out7, res_data7;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_r(in_r),
        .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_opcode(res_opcode), .res_err(res_err), .busy(busy)
    );

    alu_issue_ctrl #(.LAT_MUL(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready7),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_r(in_r),
        .alu_a(alu_a7), .alu_b(alu_b7), .alu_r(alu_r7), .alu_opcode(alu_opcode7),
        .alu_out(alu_out7), .res_valid(res_valid7), .res_ready(res_ready),
        .res_data(res_data7), .res_opcode(res_opcode7), .res_err(res_err7), .busy(busy7)
    );

    // Reference ALU function (the ALU itself lives outside the DUT).
    function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] r);
        logic [31:0] t;
        logic [5:0]  rc;
        t  = '0;
        rc = 6'd32 - {1'b0, r};
        case (op)
            4'd0:  return {32'd0, a} + {32'd0, b};
            4'd1:  return {32'd0, a} - {32'd0, b};
            4'd2:  return {32'd0, a} * {32'd0, b};
            4'd3:  t = (b == 32'd0) ? 32'd0 : a / b;
            4'd4:  t = a << r;
            4'd5:  t = a >> r;
            4'd6:  t = (a << r) | (a >> rc);
            4'd7:  t = (a >> r) | (a << rc);
            4'd8:  t = {31'd0, a < b};
            4'd9:  t = a | b;
            4'd10: t = a & b;
            4'd11: t = ~a;
            4'd12: t = a ^ b;
            4'd13: t = a;
            4'd14: t = b;
            default: return {a, b};
        endcase
        return {32'd0, t};
    endfunction

    assign alu_out  = alu_f(alu_opcode, alu_a, alu_b, alu_r);
    assign alu_out7 = alu_f(alu_opcode7, alu_a7, alu_b7, alu_r7);

    function automatic int lat_of(input logic [3:0] op, input int lmul);
        if (TRAP && op == 4'hF) return 0;
        case (op)
            4'd0, 4'd1:             return 2;
            4'd2:                   return lmul;
            4'd4, 4'd5, 4'd6, 4'd7: return 1;
            default:                return 0;
        endcase
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Timeline model: one op outstanding, result due L+1 edges after accept.
    logic        m_pending = 1'b0, m_rvalid = 1'b0, m_perr = 1'b0, m_rerr = 1'b0;
    int          m_due = 0, m_del = 0;
    logic [63:0] m_pdata = '0, m_rdata = '0;
    logic [3:0]  m_pop = '0, m_rop = '0, m_op = '0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [4:0]  m_r = '0;
    logic        m_in_ready;
    assign m_in_ready = !m_pending && (!m_rvalid || res_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0; m_rvalid <= 1'b0; m_rdata <= '0; m_rop <= '0; m_rerr <= 1'b0;
            m_a <= '0; m_b <= '0; m_r <= '0; m_op <= '0;
        end else begin
            if (m_pending && cyc == m_due) begin
                m_pending <= 1'b0; m_rvalid <= 1'b1;
                m_rdata <= m_pdata; m_rop <= m_pop; m_rerr <= m_perr;
            end else if (m_rvalid && res_ready) begin
                m_rvalid <= 1'b0;
                m_del <= m_del + 1;
            end
            if (in_valid && m_in_ready) begin
                m_pending <= 1'b1;
                m_due <= cyc + lat_of(in_opcode, L_MUL) + 1;
                m_a <= in_a; m_b <= in_b; m_r <= in_r; m_op <= in_opcode; m_pop <= in_opcode;
                if (TRAP && in_opcode == 4'hF) begin
                    m_pdata <= '0; m_perr <= 1'b1;
                end else begin
                    m_pdata <= alu_f(in_opcode, in_a, in_b, in_r); m_perr <= 1'b0;
                end
            end
        end
    end

    typedef struct {
        int          cyc;
        bit          d7;
        bit          v;
        bit          cd;
        logic [63:0] data;
        logic [3:0]  op;
        bit          err;
    } pin_t;
    pin_t pins[$];

    int checks = 0, errors = 0, pins_hit = 0, dut_del = 0, timeouts = 0;
    bit fin_req = 1'b0, fin_done = 1'b0, rnd_ready = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("in_ready", 64'(in_ready), 64'(m_in_ready));
        check("busy", 64'(busy), 64'(m_pending | m_rvalid));
        check("res_valid", 64'(res_valid), 64'(m_rvalid));
        check("res_data", res_data, m_rdata);
        check("res_opcode", 64'(res_opcode), 64'(m_rop));
        check("res_err", 64'(res_err), 64'(m_rerr));
        check("alu_a", 64'(alu_a), 64'(m_a));
        check("alu_b", 64'(alu_b), 64'(m_b));
        check("alu_r", 64'(alu_r), 64'(m_r));
        check("alu_opcode", 64'(alu_opcode), 64'(m_op));
        if (!rst_n) begin
            check("rst_res_valid", 64'(res_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_busy", 64'(busy), 64'd0);
        end
        if (rst_n && res_valid && res_ready) dut_del++;
        for (int i = 0; i < pins.size(); i++) begin
            if (pins[i].cyc == cyc) begin
                pins_hit++;
                if (pins[i].d7) begin
                    check($sformatf("pin%0d_valid7", i), 64'(res_valid7), 64'(pins[i].v));
                    check($sformatf("pin%0d_busy7", i), 64'(busy7), 64'd1);
                    check($sformatf("pin%0d_ready7", i), 64'(in_ready7), 64'(pins[i].v));
                    if (pins[i].cd) begin
                        check($sformatf("pin%0d_data7", i), res_data7, pins[i].data);
                        check($sformatf("pin%0d_op7", i), 64'(res_opcode7), 64'(pins[i].op));
                        check($sformatf("pin%0d_err7", i), 64'(res_err7), 64'(pins[i].err));
                    end
                end else begin
                    check($sformatf("pin%0d_valid", i), 64'(res_valid), 64'(pins[i].v));
                    if (pins[i].cd) begin
                        check($sformatf("pin%0d_data", i), res_data, pins[i].data);
                        check($sformatf("pin%0d_op", i), 64'(res_opcode), 64'(pins[i].op));
                        check($sformatf("pin%0d_err", i), 64'(res_err), 64'(pins[i].err));
                    end
                end
            end
        end
        if (fin_req && !fin_done) begin
            check("delivered", 64'(dut_del), 64'(m_del));
            check("pins_hit", 64'(pins_hit), 64'(pins.size()));
            check("stim_timeouts", 64'(timeouts), 64'd0);
            fin_done = 1'b1;
        end
    end

    task automatic pin(input int c, input bit d7, input bit v, input bit cd,
                       input logic [63:0] d, input logic [3:0] op, input bit e);
        pin_t p;
        p.cyc = c; p.d7 = d7; p.v = v; p.cd = cd; p.data = d; p.op = op; p.err = e;
        pins.push_back(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents an op until the model accepts it; acc = cycle index seen after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output int acc);
        int n;
        n = 0;
        acc = -1;
        in_opcode = op; in_a = a; in_b = b; in_r = r; in_valid = 1'b1;
        while (acc < 0 && n < 100) begin
            @(negedge clk);
            if (m_in_ready) acc = cyc + 1;
            tick();
            n++;
        end
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_opcode = 4'($urandom_range(0, 15));
        if (acc < 0) begin
            timeouts++;
            acc = cyc;
        end
    endtask

    initial begin
        int acc;
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // mul 3*5 with default latency, then a mul killed by reset mid-EXEC
        issue(4'd2, 32'd3, 32'd5, 5'd0, acc);
        pin(acc + 4, 0, 0, 0, '0, '0, 0);
        pin(acc + 5, 0, 1, 1, 64'd15, 4'd2, 0);
        wait_cyc(acc + 5);
        issue(4'd2, 32'd3, 32'd5, 5'd0, acc);
        pin(acc + 5, 0, 0, 0, '0, '0, 0);
        wait_cyc(acc + 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // add carry-out into bit 32
        issue(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, acc);
        pin(acc + 2, 0, 0, 0, '0, '0, 0);
        pin(acc + 3, 0, 1, 1, 64'h1_0000_0000, 4'd0, 0);
        wait_cyc(acc + 3);

        // shift then xor, back to back
        issue(4'd4, 32'd1, 32'd0, 5'd4, acc);
        pin(acc + 1, 0, 0, 0, '0, '0, 0);
        pin(acc + 2, 0, 1, 1, 64'd16, 4'd4, 0);
        issue(4'd12, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0, acc);
        pin(acc, 0, 0, 0, '0, '0, 0);
        pin(acc + 1, 0, 1, 1, 64'h0F0F_F0F0, 4'd12, 0);
        wait_cyc(acc + 2);

        // result stall for 10 cycles, then same-edge handshake and accept
        res_ready = 1'b0;
        issue(4'd1, 32'd10, 32'd3, 5'd0, acc);
        for (int k = 3; k <= 12; k++) pin(acc + k, 0, 1, 1, 64'd7, 4'd1, 0);
        pin(acc + 13, 0, 0, 0, '0, '0, 0);
        pin(acc + 15, 0, 0, 0, '0, '0, 0);
        pin(acc + 16, 0, 1, 1, 64'd2, 4'd0, 0);
        wait_cyc(acc + 12);
        res_ready = 1'b1;
        issue(4'd0, 32'd1, 32'd1, 5'd0, n);
        wait_cyc(acc + 17);

        // opcode 4'b1111
        issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, acc);
        if (TRAP) pin(acc + 1, 0, 1, 1, 64'd0, 4'hF, 1);
        else      pin(acc + 1, 0, 1, 1, 64'h1234_5678_9ABC_DEF0, 4'hF, 0);
        wait_cyc(acc + 2);

        // LAT_MUL=7 instance against the default one, both freshly reset
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(4'd2, 32'd6, 32'd7, 5'd0, acc);
        for (int k = 1; k <= 7; k++) pin(acc + k, 1, 0, 0, '0, '0, 0);
        pin(acc + 8, 1, 1, 1, 64'd42, 4'd2, 0);
        pin(acc + 5, 0, 1, 1, 64'd42, 4'd2, 0);
        wait_cyc(acc + 9);

        // random mix with random result back-pressure
        rnd_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            issue(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)), acc);
        end
        rnd_ready = 1'b0;
        res_ready = 1'b1;
        repeat (20) tick();

        fin_req = 1'b1;
        n = 0;
        while (!fin_done && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (!fin_done) $display("FAIL final_check no_response got=0 want=1");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
